fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and the IF/ID pipeline register.
// Handles hazard stalls, shared-SRAM conflicts, and branch redirects.
// With a delay slot, a redirect that cannot fetch its delay slot is parked
// in tgt_r (PEND) until the slot is fetched.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_WORD   = 16'h0800,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        memConflict,
    input  logic        redirect,
    input  logic [15:0] redirectTarget,
    input  logic [15:0] instrIn,
    output logic [15:0] pcOut,
    output logic [15:0] idInstr,
    output logic [15:0] idPc,
    output logic        idValid
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    localparam bit DS_EN = (DELAY_SLOT != 0);

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic [15:0] id_instr_r, id_instr_s;
    logic [15:0] id_pc_r, id_pc_s;
    logic        id_valid_r, id_valid_s;
    logic [15:0] tgt_r, tgt_s;
    logic        fire_s;
    logic        take_s;

    // The fetch address goes straight to instruction memory.
    assign pcOut   = pc_r;
    assign idInstr = id_instr_r;
    assign idPc    = id_pc_r;
    assign idValid = id_valid_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-register computation; at most one PC update per edge.
    always_comb begin
        fire_s     = !stall && !memConflict;
        // Redirects are only honoured when not stalled and nothing is pending.
        take_s     = redirect && !stall && (state_r == ST_RUN);
        state_s    = state_r;
        pc_s       = pc_r;
        id_instr_s = id_instr_r;
        id_pc_s    = id_pc_r;
        id_valid_s = id_valid_r;
        tgt_s      = tgt_r;

        if (stall) begin
            // Full hold of IF, ID and FSM.
            state_s = state_r;
        end else if (!DS_EN && take_s) begin
            // No delay slot: the instruction behind the branch is squashed.
            pc_s       = redirectTarget;
            id_instr_s = NOP_WORD;
            id_valid_s = 1'b0;
        end else if (fire_s) begin
            id_instr_s = instrIn;
            id_pc_s    = pc_r + 16'h0001;
            id_valid_s = 1'b1;
            case (state_r)
                ST_RUN: begin
                    if (take_s) begin
                        pc_s = redirectTarget;
                    end else begin
                        pc_s = pc_r + 16'h0001;
                    end
                end
                ST_PEND: begin
                    // Delay slot fetched now; jump to the parked target.
                    pc_s    = tgt_r;
                    state_s = ST_RUN;
                end
                default: begin
                    pc_s    = pc_r + 16'h0001;
                    state_s = ST_RUN;
                end
            endcase
        end else begin
            // SRAM busy: insert a bubble, keep the PC and idPc.
            id_instr_s = NOP_WORD;
            id_valid_s = 1'b0;
            if (DS_EN && take_s) begin
                tgt_s   = redirectTarget;
                state_s = ST_PEND;
            end else begin
                tgt_s = tgt_r;
            end
        end
    end

    // PC, IF/ID and parked-target registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r       <= RESET_PC;
            id_instr_r <= NOP_WORD;
            id_pc_r    <= 16'h0000;
            id_valid_r <= 1'b0;
            tgt_r      <= 16'h0000;
        end else begin
            pc_r       <= pc_s;
            id_instr_r <= id_instr_s;
            id_pc_r    <= id_pc_s;
            id_valid_r <= id_valid_s;
            tgt_r      <= tgt_s;
        end
    end

endmodule
